// File: rtl/mem_pkg.sv
// Shared definitions for the line memory and the data cache.
// Holds the line type, the in-line byte offset width and the FSM state encoding.
// Pure declarations; no logic.
package mem_pkg;

  localparam int LINE_BITS   = 256;
  localparam int OFFSET_BITS = 5;

  typedef logic [LINE_BITS-1:0] line_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

endpackage

// File: rtl/line_ram.sv
// Line storage array: DEPTH lines of DATA_WIDTH bits, written whole.
// Latency: write lands at the clock edge with we=1; read is combinational.
// Backpressure: none; one access per cycle, caller owns sequencing.
module line_ram #(
  parameter int DEPTH      = 512,
  parameter int DATA_WIDTH = 256,
  parameter int IDX_BITS   = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [IDX_BITS-1:0]   idx,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Whole-line write; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/line_memory.sv
// Off-chip line memory model behind the data cache: one line read/write per request.
// Latency: accept at edge N -> ack_o (and read data) high in the cycle after edge N+LATENCY.
// Backpressure: inputs ignored while busy, no queueing; enable_i held past ack re-issues.
module line_memory
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 512,
  parameter int LATENCY    = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic                  write_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  ack_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  busy_o
);

  localparam int IDX_BITS = $clog2(DEPTH);
  localparam int CNT_BITS = $clog2(LATENCY + 1);
  // The ACK state is entered LATENCY-1 edges after accept; the registered
  // ack_o then appears one edge later, giving LATENCY in total.
  localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(LATENCY - 1);

  state_t                state;
  state_t                state_next;
  logic [CNT_BITS-1:0]   count;
  logic                  accept;
  logic                  wr_q;
  logic [IDX_BITS-1:0]   idx_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  unused_addr;

  // Offset bits and bits above the array size do not select a line.
  assign unused_addr = ^{addr_i[ADDR_WIDTH-1:OFFSET_BITS+IDX_BITS], addr_i[OFFSET_BITS-1:0]};

  assign accept = (state == IDLE) && enable_i;
  assign busy_o = (state != IDLE);

  // A reset landing on the ACK edge aborts the write as well as the ack.
  assign ram_we = (state == ACK) && wr_q && !rst_i;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: accept in IDLE, count down in WAIT, single ACK cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (enable_i) begin
          state_next = (LATENCY == 1) ? ACK : WAIT;
        end
      end
      WAIT: begin
        if (count == CNT_BITS'(1)) begin
          state_next = ACK;
        end
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Latency counter: loaded at accept, decremented every WAIT cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count <= '0;
    end else if (accept) begin
      count <= CNT_LOAD;
    end else if (state == WAIT) begin
      count <= count - 1'b1;
    end
  end

  // Request latches: inputs are only looked at on the accept edge.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      wr_q    <= write_i;
      idx_q   <= addr_i[OFFSET_BITS+IDX_BITS-1:OFFSET_BITS];
      wdata_q <= data_i;
    end
  end

  // Completion outputs, registered off the ACK state; reads sample the array
  // in ACK so any earlier completed write is seen.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_o  <= 1'b0;
      data_o <= '0;
    end else begin
      ack_o  <= (state == ACK);
      data_o <= ((state == ACK) && !wr_q) ? ram_rdata : '0;
    end
  end

  // Catch an undriven request strobe while waiting for work.
  always_ff @(posedge clk_i) begin
    if (!rst_i && state == IDLE) begin
      assert (!$isunknown(enable_i))
        else $error("line_memory: enable_i is X/Z in IDLE");
    end
  end

  line_ram #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_BITS   (IDX_BITS)
  ) u_ram (
    .clk   (clk_i),
    .we    (ram_we),
    .idx   (idx_q),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

endmodule
